// File: rtl/operand_issue_stage_pkg.sv
// Shared CPU defaults for the operand issue stage: datapath widths and the
// layout of the opaque control payload carried alongside each instruction.
package operand_issue_stage_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int RA_W_DEF    = 5;
   localparam int CNT_W_DEF   = 16;
   localparam int NUM_BYP_DEF = 3;

   // Control payload layout. The issue stage never looks inside it; the
   // later stages decode these fields.
   typedef struct packed {
      logic [7:0]  fu_op;    // functional-unit opcode
      logic [4:0]  rd;       // destination register
      logic        rd_we;    // destination write enable
      logic [3:0]  mem_op;   // load/store kind
      logic [15:0] exc;      // exception code / flags
      logic [29:0] rsvd;     // reserved for future control bits
   } payload_t;

   localparam int PAY_W_DEF = $bits(payload_t);

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one register operand against the bypass network: the youngest
// (lowest-index) matching producer wins, an unready match stalls, and no
// match falls back to the register file. Register 0 is hard-wired to zero.
module operand_bypass_mux #(
   parameter int NUM_BYP = 3,
   parameter int XLEN    = 32,
   parameter int RA_W    = 5
) (
   input  logic [RA_W-1:0]         rs_i,
   input  logic [XLEN-1:0]         rf_rdata_i,
   input  logic [NUM_BYP-1:0]      byp_we_i,
   input  logic [NUM_BYP*RA_W-1:0] byp_addr_i,
   input  logic [NUM_BYP-1:0]      byp_rdy_i,
   input  logic [NUM_BYP*XLEN-1:0] byp_data_i,
   output logic [XLEN-1:0]         operand_o,
   output logic                    ok_o
);

   logic hit;

   // Priority search over bypass sources, youngest first.
   always_comb begin
      // NOTE: every output gets a default before any branch so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      operand_o = rf_rdata_i;
      ok_o      = 1'b1;
      hit       = 1'b0;
      if (rs_i == '0) begin
         operand_o = '0;
      end else begin
         for (int i = 0; i < NUM_BYP; i++) begin
            if (!hit && byp_we_i[i] && (byp_addr_i[i*RA_W +: RA_W] == rs_i)) begin
               hit = 1'b1;
               if (byp_rdy_i[i]) begin
                  operand_o = byp_data_i[i*XLEN +: XLEN];
                  ok_o      = 1'b1;
               end else begin
                  operand_o = '0;
                  ok_o      = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/operand_issue_stage.sv
// Single-entry operand issue stage. Holds one instruction, resolves its
// register operands every cycle from the bypass network / register file and
// hands it on once both operands are available.
module operand_issue_stage
   import operand_issue_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NUM_BYP = NUM_BYP_DEF,
   parameter int RA_W    = RA_W_DEF,
   parameter int PAY_W   = PAY_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_allow,
   input  logic [RA_W-1:0]         in_rs1,
   input  logic [RA_W-1:0]         in_rs2,
   input  logic                    in_use_rs1,
   input  logic                    in_use_rs2,
   input  logic [XLEN-1:0]         in_pc,
   input  logic [XLEN-1:0]         in_imm,
   input  logic [PAY_W-1:0]        in_payload,
   output logic [RA_W-1:0]         rf_raddr1,
   output logic [RA_W-1:0]         rf_raddr2,
   input  logic [XLEN-1:0]         rf_rdata1,
   input  logic [XLEN-1:0]         rf_rdata2,
   input  logic [NUM_BYP-1:0]      byp_we,
   input  logic [NUM_BYP*RA_W-1:0] byp_addr,
   input  logic [NUM_BYP-1:0]      byp_rdy,
   input  logic [NUM_BYP*XLEN-1:0] byp_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_allow,
   output logic [XLEN-1:0]         out_src1,
   output logic [XLEN-1:0]         out_src2,
   output logic [XLEN-1:0]         out_pc,
   output logic [PAY_W-1:0]        out_payload,
   output logic [CNT_W-1:0]        stall_cnt
);

   typedef struct packed {
      logic [RA_W-1:0]  rs1;
      logic [RA_W-1:0]  rs2;
      logic             use_rs1;
      logic             use_rs2;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic [PAY_W-1:0] payload;
   } entry_t;

   logic             valid_q, valid_d;
   entry_t           entry_q, entry_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic [XLEN-1:0]  reg_src1, reg_src2;
   logic             reg_ok1, reg_ok2;
   logic             ready_go;

   assign rf_raddr1 = entry_q.rs1;
   assign rf_raddr2 = entry_q.rs2;

   operand_bypass_mux #(.NUM_BYP(NUM_BYP), .XLEN(XLEN), .RA_W(RA_W)) u_mux_src1 (
      .rs_i       (entry_q.rs1),
      .rf_rdata_i (rf_rdata1),
      .byp_we_i   (byp_we),
      .byp_addr_i (byp_addr),
      .byp_rdy_i  (byp_rdy),
      .byp_data_i (byp_data),
      .operand_o  (reg_src1),
      .ok_o       (reg_ok1)
   );

   operand_bypass_mux #(.NUM_BYP(NUM_BYP), .XLEN(XLEN), .RA_W(RA_W)) u_mux_src2 (
      .rs_i       (entry_q.rs2),
      .rf_rdata_i (rf_rdata2),
      .byp_we_i   (byp_we),
      .byp_addr_i (byp_addr),
      .byp_rdy_i  (byp_rdy),
      .byp_data_i (byp_data),
      .operand_o  (reg_src2),
      .ok_o       (reg_ok2)
   );

   // Operands are resolved live, so a stalled entry picks up late bypass data.
   always_comb begin
      ready_go    = (!entry_q.use_rs1 || reg_ok1) && (!entry_q.use_rs2 || reg_ok2);
      out_valid   = valid_q && ready_go && !flush;
      in_allow    = !valid_q || (ready_go && out_allow);
      out_src1    = entry_q.use_rs1 ? reg_src1 : entry_q.pc;
      out_src2    = entry_q.use_rs2 ? reg_src2 : entry_q.imm;
      out_pc      = entry_q.pc;
      out_payload = entry_q.payload;
      stall_cnt   = stall_q;
   end

   // Next-state: flush drops both the held and the incoming entry; otherwise
   // the slot refills whenever it is free or being handed off.
   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      stall_d = stall_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_allow) begin
         valid_d = in_valid;
         if (in_valid) begin
            entry_d.rs1     = in_rs1;
            entry_d.rs2     = in_rs2;
            entry_d.use_rs1 = in_use_rs1;
            entry_d.use_rs2 = in_use_rs2;
            entry_d.pc      = in_pc;
            entry_d.imm     = in_imm;
            entry_d.payload = in_payload;
         end
      end
      if (valid_q && !ready_go && !flush && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // State registers; reset outranks flush and capture.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         valid_q <= 1'b0;
         entry_q <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
         stall_q <= stall_d;
      end
   end

endmodule
